pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Front-end controller for the chain of `pipelinestage` blocks. Owns the program counter, fetches opcodes from program memory through a valid-qualified port, and feeds the first stage's `PREV_STAGE_IN`. It also drives a common stage-advance enable and injects NOP bubbles on reset fill, fetch misses and flushes. It sits between program ROM/RAM and stage 0 of the control pipeline, and takes `STALL` and `FLUSH` back from late-stage control lines.

## Interface
- `STAGES`, 3: number of pipeline stages downstream; sets fill/flush bubble count (legal 1–15).
- `NOP_OPCODE`, 8'h00: opcode injected as a bubble.
- `RESET_PC`, 16'h0000: PC value after reset.
- `CLK`  in  1: single clock, all state updates on rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `FETCH_ADDR`  out  16: current PC; registered.
- `FETCH_DATA`  in  8: opcode at `FETCH_ADDR`; sampled at the edge.
- `FETCH_VALID`  in  1: `FETCH_DATA` is valid this cycle.
- `STALL`  in  1: hold the pipeline; no advance, no fetch.
- `FLUSH`  in  1: taken branch; discard fetched/in-flight opcodes.
- `FLUSH_ADDR`  in  16: new PC on `FLUSH`.
- `STAGE0_OPCODE`  out  8: drives stage-0 `PREV_STAGE_IN`; registered.
- `ADVANCE`  out  1: registered; high means stage latches capture on the next edge.
- `BUSY_FILL`  out  1: high while in FILL or FLUSHING.
- `BUBBLE_COUNT`  out  8: saturating count of injected bubbles.

## Operation
- States: FILL, RUN, FLUSHING. The 4-bit counter `cnt` counts remaining bubbles.
- Event priority per edge: `RST` > `FLUSH` > `STALL` > fetch.
- `RST`:
  - state=FILL, `cnt`=STAGES, PC=RESET_PC, `STAGE0_OPCODE`=NOP_OPCODE.
  - `ADVANCE`=0, `BUBBLE_COUNT`=0.
- FILL:
  - Each cycle: emit NOP, `ADVANCE`=1, `cnt`−1, bubble count+1. PC holds.
  - At `cnt`=1, go to RUN.
  - `STALL` and `FLUSH` are ignored in FILL.
- RUN, in priority order:
  - `FLUSH`: PC=FLUSH_ADDR, emit NOP, `ADVANCE`=1, bubble+1. If STAGES>1, go to FLUSHING with `cnt`=STAGES−1; otherwise stay in RUN.
  - `STALL`: `ADVANCE`=0. PC, `STAGE0_OPCODE` and `BUBBLE_COUNT` hold. `FETCH_DATA` is not consumed.
  - `FETCH_VALID`: `STAGE0_OPCODE`=FETCH_DATA, PC+1 (wraps FFFF→0000), `ADVANCE`=1.
  - Otherwise (miss): emit NOP, `ADVANCE`=1, bubble+1, PC holds.
- FLUSHING:
  - Emit NOP, `ADVANCE`=1, bubble+1, `cnt`−1.
  - Fetches are not consumed and PC holds at the flush target.
  - At `cnt`=1, go to RUN.
  - A new `FLUSH` reloads PC=FLUSH_ADDR and restarts `cnt`=STAGES−1.
  - `STALL` is ignored.
- `BUBBLE_COUNT` saturates at 8'hFF and clears only on `RST`.
- `BUSY_FILL` = (state≠RUN), registered with state.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Fetch latency: `FETCH_ADDR`=A in cycle n, `FETCH_VALID`=1 in cycle n → `STAGE0_OPCODE`=mem[A] and `FETCH_ADDR`=A+1 in cycle n+1.
- Sustained throughput is one opcode per cycle.
- Flush latency:
  - `FLUSH` sampled at edge k → `FETCH_ADDR`=FLUSH_ADDR from cycle k+1.
  - First opcode from the target appears at cycle k+STAGES+1, assuming valid fetches.
- After `RST` deasserts at edge r: NOPs in cycles r+1..r+STAGES, first real opcode in cycle r+STAGES+1.
- `RST` asserted mid-FLUSHING or mid-stall returns to the FILL reset values on that edge; no partial state survives.
- `STALL` and `FLUSH` together in RUN: `FLUSH` wins.

## Structure
- Shared header `pipeline_defs.vh` holds:
  - state encodings `SEQ_FILL`=2'd0, `SEQ_RUN`=2'd1, `SEQ_FLUSHING`=2'd2;
  - default `NOP_OPCODE`.
- The PC register and incrementer form a natural sub-module, `pc_counter`, with load, increment and hold inputs.
- Everything else stays flat in `pipeline_sequencer`.

## Test plan
- Reset fill: STAGES=3, RST pulse, `FETCH_VALID`=1 with mem[0]=8'h12 → `STAGE0_OPCODE`=00,00,00 (bubble count 3), then 12; `FETCH_ADDR`=0001.
- Streaming: mem[0..3]=11,22,33,44, always valid → one opcode per cycle, `ADVANCE` stays 1, `FETCH_ADDR` 0001→0004.
- Stall: assert `STALL` for 2 cycles while `STAGE0_OPCODE`=22 → `ADVANCE`=0 and 22/PC held both cycles; resumes with 33.
- Flush: `FLUSH` with `FLUSH_ADDR`=16'h0100 at PC=0003 → `FETCH_ADDR`=0100, three NOPs (bubble count +3), then mem[0x100].
- Fetch miss and wrap: PC=FFFF, `FETCH_VALID`=0 for 1 cycle → one NOP with PC held; next valid → PC=0000.
- Edge cases:
  - `FLUSH`+`STALL` together → flush taken.
  - `RST` mid-FLUSHING → FILL reset values.
  - 300 misses → `BUBBLE_COUNT` saturates at FF.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer_pkg
//   Shared definitions for the pipeline front-end sequencer:
//   - seq_state_t     : sequencer state encoding (FILL / RUN / FLUSHING)
//   - SEQ_NOP_DEFAULT : default opcode injected as a bubble
//   - BUBBLE_MAX      : saturation value of the bubble counter
//   - bubble_inc()    : saturating +1 for the bubble counter
// ---------------------------------------------------------------------------
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_FILL     = 2'd0,
    SEQ_RUN      = 2'd1,
    SEQ_FLUSHING = 2'd2
  } seq_state_t;

  localparam logic [7:0] SEQ_NOP_DEFAULT = 8'h00;
  localparam logic [7:0] BUBBLE_MAX      = 8'hFF;

  // The bubble counter sticks at its maximum rather than wrapping, so a
  // long run of misses never makes the count look small again.
  function automatic logic [7:0] bubble_inc(input logic [7:0] value);
    return (value == BUBBLE_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_pc_counter.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer_pc_counter
//   Program counter register with load / hold / increment control.
//   Priority: reset > load > hold > increment; with none active it holds.
//   Ports:
//     i_clk, i_rst   : clock, synchronous active-high reset (PC <= RESET_PC)
//     i_load         : load i_load_value (flush target)
//     i_load_value   : new PC value for a load
//     i_hold         : keep the current PC (stall / bubble phases)
//     i_inc          : advance to the next address, wrapping FFFF -> 0000
//     o_pc           : registered program counter
// ---------------------------------------------------------------------------
module pipeline_sequencer_pc_counter #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_load_value,
  input  logic        i_hold,
  input  logic        i_inc,
  output logic [15:0] o_pc
);

  logic [15:0] r_pc;

  // Hold outranks increment so the parent can flag a stall without having
  // to mask its own fetch-valid based increment request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_value;
    end else if (i_hold) begin
      r_pc <= r_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + 16'd1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//   Front-end controller for the pipeline stage chain. Owns the PC, fetches
//   opcodes through a valid-qualified port, feeds stage 0, drives the common
//   stage-advance enable and injects NOP bubbles on reset fill, fetch misses
//   and flushes. All outputs are registered.
//   Ports:
//     i_clk, i_rst      : clock, synchronous active-high reset
//     o_fetch_addr      : current PC presented to program memory
//     i_fetch_data      : opcode at o_fetch_addr
//     i_fetch_valid     : i_fetch_data is valid this cycle
//     i_stall           : hold the pipeline (no advance, no fetch)
//     i_flush           : taken branch, discard fetched / in-flight opcodes
//     i_flush_addr      : new PC on a flush
//     o_stage0_opcode   : opcode driven into stage 0
//     o_advance         : stage latches capture on the next edge
//     o_busy_fill       : high while filling or flushing
//     o_bubble_count    : saturating count of injected bubbles
// ---------------------------------------------------------------------------
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned STAGES     = 3,
  parameter logic [7:0]  NOP_OPCODE = SEQ_NOP_DEFAULT,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_fetch_addr,
  input  logic [7:0]  i_fetch_data,
  input  logic        i_fetch_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [15:0] i_flush_addr,
  output logic [7:0]  o_stage0_opcode,
  output logic        o_advance,
  output logic        o_busy_fill,
  output logic [7:0]  o_bubble_count
);

  localparam logic [3:0] L_CNT_FILL  = 4'(STAGES);
  localparam logic [3:0] L_CNT_FLUSH = 4'(STAGES - 1);

  seq_state_t  r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_opcode;
  logic        r_advance;
  logic        r_busy;
  logic [7:0]  r_bubbles;

  logic        w_pc_load;
  logic        w_pc_hold;
  logic        w_pc_inc;

  // Flushes are honoured everywhere except during the reset fill. Outside
  // RUN the PC is parked (fill, or sitting on the flush target while the
  // bubbles drain); in RUN a stall parks it and a valid fetch moves it on.
  assign w_pc_load = i_flush && (r_state != SEQ_FILL);
  assign w_pc_hold = (r_state != SEQ_RUN) || i_stall;
  assign w_pc_inc  = (r_state == SEQ_RUN) && i_fetch_valid;

  pipeline_sequencer_pc_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_pc_load),
    .i_load_value (i_flush_addr),
    .i_hold       (w_pc_hold),
    .i_inc        (w_pc_inc),
    .o_pc         (o_fetch_addr)
  );

  // Sequencer FSM. r_cnt holds the number of bubbles still to emit in FILL
  // and FLUSHING; the state flips to RUN on the edge that emits the last
  // one, so the following edge already fetches. r_busy is kept in step with
  // the next state so it is a clean registered output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= SEQ_FILL;
      r_cnt     <= L_CNT_FILL;
      r_opcode  <= NOP_OPCODE;
      r_advance <= 1'b0;
      r_busy    <= 1'b1;
      r_bubbles <= 8'd0;
    end else begin
      case (r_state)
        SEQ_FILL: begin
          r_opcode  <= NOP_OPCODE;
          r_advance <= 1'b1;
          r_bubbles <= bubble_inc(r_bubbles);
          r_cnt     <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= SEQ_RUN;
            r_busy  <= 1'b0;
          end
        end
        SEQ_RUN: begin
          if (i_flush) begin
            r_opcode  <= NOP_OPCODE;
            r_advance <= 1'b1;
            r_bubbles <= bubble_inc(r_bubbles);
            if (STAGES > 1) begin
              r_state <= SEQ_FLUSHING;
              r_cnt   <= L_CNT_FLUSH;
              r_busy  <= 1'b1;
            end
          end else if (i_stall) begin
            r_advance <= 1'b0;
          end else if (i_fetch_valid) begin
            r_opcode  <= i_fetch_data;
            r_advance <= 1'b1;
          end else begin
            r_opcode  <= NOP_OPCODE;
            r_advance <= 1'b1;
            r_bubbles <= bubble_inc(r_bubbles);
          end
        end
        SEQ_FLUSHING: begin
          r_opcode  <= NOP_OPCODE;
          r_advance <= 1'b1;
          r_bubbles <= bubble_inc(r_bubbles);
          if (i_flush) begin
            r_cnt <= L_CNT_FLUSH;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
              r_state <= SEQ_RUN;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= SEQ_FILL;
          r_cnt     <= L_CNT_FILL;
          r_opcode  <= NOP_OPCODE;
          r_advance <= 1'b0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  assign o_stage0_opcode = r_opcode;
  assign o_advance       = r_advance;
  assign o_busy_fill     = r_busy;
  assign o_bubble_count  = r_bubbles;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_sequencer
//   Self-checking bench for pipeline_sequencer (STAGES=3). A behavioural
//   model tracks "NOP slots still owed" and the PC in plain integers and is
//   stepped once per clock alongside the DUT.
// ---------------------------------------------------------------------------
module tb_pipeline_sequencer;

  localparam int         STAGES = 3;
  localparam logic [7:0] NOP    = 8'h00;

  logic        clk = 1'b0;
  logic        rst, stall, flush, fetchValid;
  logic [15:0] flushAddr;
  logic [15:0] fetchAddr;
  logic [7:0]  fetchData;
  logic [7:0]  stage0Opcode;
  logic        advance, busyFill;
  logic [7:0]  bubbleCount;

  logic [7:0]  mem [0:65535];

  int testCount = 0;
  int failCount = 0;

  // Model state
  int          mOwed;
  bit          mFilling;
  logic [15:0] mPc;
  logic [7:0]  mOp;
  bit          mAdv;
  int          mBub;

  always #5 clk = ~clk;

  assign fetchData = mem[fetchAddr];

  pipeline_sequencer #(
    .STAGES     (STAGES),
    .NOP_OPCODE (NOP),
    .RESET_PC   (16'h0000)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_fetch_addr    (fetchAddr),
    .i_fetch_data    (fetchData),
    .i_fetch_valid   (fetchValid),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_flush_addr    (flushAddr),
    .o_stage0_opcode (stage0Opcode),
    .o_advance       (advance),
    .o_busy_fill     (busyFill),
    .o_bubble_count  (bubbleCount)
  );

  // One clock of the reference behaviour: a flush (outside the reset fill)
  // retargets the PC and owes STAGES bubbles; owed bubbles are paid first,
  // then stall, then a valid fetch, else a miss bubble.
  task automatic modelStep(input bit r, input bit s, input bit f,
                           input logic [15:0] fa, input bit v);
    if (r) begin
      mOwed = STAGES; mFilling = 1; mPc = 16'h0000;
      mOp = NOP; mAdv = 0; mBub = 0;
      return;
    end
    if (f && !mFilling) begin
      mPc   = fa;
      mOwed = STAGES;
    end
    if (mOwed > 0) begin
      mOp  = NOP; mAdv = 1;
      mBub = (mBub < 255) ? mBub + 1 : 255;
      mOwed--;
      if (mOwed == 0) mFilling = 0;
    end else if (s) begin
      mAdv = 0;
    end else if (v) begin
      mOp = mem[mPc]; mPc = mPc + 16'd1; mAdv = 1;
    end else begin
      mOp  = NOP; mAdv = 1;
      mBub = (mBub < 255) ? mBub + 1 : 255;
    end
  endtask

  task automatic checkEq(input string name, input logic [15:0] obs,
                         input logic [15:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".addr"},   fetchAddr,              mPc);
    checkEq({tag, ".opcode"}, {8'h00, stage0Opcode},  {8'h00, mOp});
    checkEq({tag, ".adv"},    {15'h0, advance},       {15'h0, mAdv});
    checkEq({tag, ".busy"},   {15'h0, busyFill},      {15'h0, (mOwed > 0)});
    checkEq({tag, ".bubble"}, {8'h00, bubbleCount},   16'(mBub));
  endtask

  // Drive one cycle of inputs at the falling edge, step the model on the
  // rising edge and compare just after it.
  task automatic applyStimulus(input bit r, input bit s, input bit f,
                               input logic [15:0] fa, input bit v,
                               input string tag);
    @(negedge clk);
    rst = r; stall = s; flush = f; flushAddr = fa; fetchValid = v;
    @(posedge clk);
    modelStep(r, s, f, fa, v);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; flushAddr = 0; fetchValid = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset fill: three NOPs then the opcode at address 0
    mem[0] = 8'h12;
    applyStimulus(1, 0, 0, 16'h0, 1, "reset");
    checkEq("reset_busy", {15'h0, busyFill}, 16'h0001);
    checkEq("reset_adv",  {15'h0, advance},  16'h0000);
    repeat (STAGES) applyStimulus(0, 0, 0, 16'h0, 1, "fill");
    checkEq("fill_bubbles", {8'h00, bubbleCount}, 16'h0003);
    applyStimulus(0, 0, 0, 16'h0, 1, "first");
    checkEq("fill_opcode", {8'h00, stage0Opcode}, 16'h0012);
    checkEq("fill_addr",   fetchAddr,             16'h0001);

    // Streaming four opcodes
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    applyStimulus(1, 0, 0, 16'h0, 1, "reset2");
    repeat (STAGES) applyStimulus(0, 0, 0, 16'h0, 1, "fill2");
    repeat (4) applyStimulus(0, 0, 0, 16'h0, 1, "stream");
    checkEq("stream_last", {8'h00, stage0Opcode}, 16'h0044);
    checkEq("stream_addr", fetchAddr,             16'h0004);

    // Stall while 22 sits in stage 0, then resume and flush at PC=3
    applyStimulus(1, 0, 0, 16'h0, 1, "reset3");
    repeat (STAGES) applyStimulus(0, 0, 0, 16'h0, 1, "fill3");
    repeat (2) applyStimulus(0, 0, 0, 16'h0, 1, "pre_stall");
    repeat (2) applyStimulus(0, 1, 0, 16'h0, 1, "stall");
    checkEq("stall_hold", {8'h00, stage0Opcode}, 16'h0022);
    applyStimulus(0, 0, 0, 16'h0, 1, "resume");
    checkEq("resume_op", {8'h00, stage0Opcode}, 16'h0033);
    applyStimulus(0, 0, 1, 16'h0100, 1, "flush");
    checkEq("flush_addr", fetchAddr, 16'h0100);
    repeat (STAGES - 1) applyStimulus(0, 0, 0, 16'h0, 1, "flushing");
    applyStimulus(0, 0, 0, 16'h0, 1, "flush_target");

    // Miss and wrap at FFFF
    applyStimulus(0, 0, 1, 16'hFFFF, 1, "flush_ffff");
    repeat (STAGES - 1) applyStimulus(0, 0, 0, 16'h0, 1, "flushing_ffff");
    applyStimulus(0, 0, 0, 16'h0, 0, "miss");
    checkEq("miss_pc_hold", fetchAddr, 16'hFFFF);
    applyStimulus(0, 0, 0, 16'h0, 1, "wrap");
    checkEq("wrap_addr", fetchAddr, 16'h0000);

    // Flush and stall together, then a re-flush mid-flushing
    applyStimulus(0, 1, 1, 16'h0200, 1, "flush_stall");
    checkEq("flush_stall_addr", fetchAddr, 16'h0200);
    applyStimulus(0, 0, 1, 16'h0300, 1, "reflush");
    repeat (STAGES + 1) applyStimulus(0, 1, 0, 16'h0, 1, "reflush_drain");

    // Reset in the middle of a flush
    applyStimulus(0, 0, 1, 16'h0500, 1, "flush_pre_rst");
    applyStimulus(1, 0, 0, 16'h0, 1, "rst_mid_flush");
    checkEq("rst_mid_bubble", {8'h00, bubbleCount}, 16'h0000);

    // Stall and flush are ignored during the reset fill
    applyStimulus(0, 1, 1, 16'h0400, 1, "fill_ignore");
    checkEq("fill_ignore_addr", fetchAddr, 16'h0000);
    repeat (STAGES) applyStimulus(0, 0, 0, 16'h0, 1, "fill_ignore_tail");

    // Saturation after a long run of misses
    applyStimulus(1, 0, 0, 16'h0, 0, "reset_sat");
    repeat (300) applyStimulus(0, 0, 0, 16'h0, 0, "sat");
    checkEq("sat_bubble", {8'h00, bubbleCount}, 16'h00FF);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0, 16'($urandom),
                    $urandom_range(0, 4) != 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
